// File: rtl/mem_stage_nlane.sv
// rtl/mem_stage_nlane.sv - N-lane memory stage serialising dcache accesses in lane order
// Bundles without aligned memory ops pass straight through; others stall until every op completes.

module mem_stage_nlane #(
  parameter int LANES   = 2,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES-1:0]           in_read_ena,
  input  logic [LANES-1:0]           in_write_ena,
  input  logic [3*LANES-1:0]         in_mem_type,
  input  logic [DATA_W*LANES-1:0]    in_addr,
  input  logic [DATA_W*LANES-1:0]    in_write_data,
  input  logic [DATA_W*LANES-1:0]    in_result,
  input  logic [LANES-1:0]           in_write_reg_need,
  input  logic [RADDR_W*LANES-1:0]   in_write_reg_addr,
  output logic                       dc_req_valid,
  input  logic                       dc_req_ready,
  output logic                       dc_req_we,
  output logic [DATA_W-1:0]          dc_req_addr,
  output logic [3:0]                 dc_req_wstrb,
  output logic [DATA_W-1:0]          dc_req_wdata,
  input  logic                       dc_resp_valid,
  input  logic [DATA_W-1:0]          dc_resp_rdata,
  output logic [LANES-1:0]           cmt_valid,
  output logic [DATA_W*LANES-1:0]    cmt_result,
  output logic [LANES-1:0]           cmt_write_reg_need,
  output logic [RADDR_W*LANES-1:0]   cmt_write_reg_addr,
  output logic [LANES-1:0]           cmt_addr_error,
  output logic                       stall_from_memory
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] ld_buf_q [LANES];

  logic [LANES-1:0]  mis_op, pending, is_load, above;
  logic              any_pending, has_next, capture, show;
  logic [IW-1:0]     first_idx, next_idx;
  logic [2:0]        sel_type;
  logic [DATA_W-1:0] sel_addr, sel_data;
  logic              sel_we;

  always_comb begin : decode
    logic [2:0] lt;
    logic [1:0] la;
    logic       mis;
    logic       memop;
    lt = '0;
    la = '0;
    mis = 1'b0;
    memop = 1'b0;
    mis_op = '0;
    pending = '0;
    is_load = '0;
    for (int l = 0; l < LANES; l++) begin
      lt = in_mem_type[3*l +: 3];
      la = in_addr[DATA_W*l +: 2];
      mis = ((lt == 3'd2 || lt == 3'd3) && la[0]) || (lt >= 3'd4 && la != 2'b00);
      memop = in_valid[l] & (in_read_ena[l] | in_write_ena[l]);
      mis_op[l] = memop & mis;
      pending[l] = memop & ~mis;
      is_load[l] = memop & ~mis & ~in_write_ena[l];
    end
  end

  // Lowest pending lane overall and lowest pending lane strictly above idx.
  always_comb begin : pick
    above = '0;
    first_idx = '0;
    next_idx = '0;
    for (int l = 0; l < LANES; l++) begin
      above[l] = pending[l] && (l > int'(idx_q));
    end
    for (int l = LANES - 1; l >= 0; l--) begin
      if (pending[l]) first_idx = IW'(l);
      if (above[l]) next_idx = IW'(l);
    end
  end

  assign any_pending = |pending;
  assign has_next    = |above;

  assign sel_type = in_mem_type[3*idx_q +: 3];
  assign sel_addr = in_addr[DATA_W*idx_q +: DATA_W];
  assign sel_data = in_write_data[DATA_W*idx_q +: DATA_W];
  assign sel_we   = in_write_ena[idx_q];

  function automatic logic [DATA_W-1:0] extract(input logic [2:0] t, input logic [1:0] a,
                                                input logic [DATA_W-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (t)
      3'd0:    extract = {{(DATA_W-8){b[7]}}, b};
      3'd1:    extract = {{(DATA_W-8){1'b0}}, b};
      3'd2:    extract = {{(DATA_W-16){h[15]}}, h};
      3'd3:    extract = {{(DATA_W-16){1'b0}}, h};
      default: extract = w;
    endcase
  endfunction

  always_comb begin : fsm
    state_d = state_q;
    idx_d = idx_q;
    stall_from_memory = 1'b0;
    dc_req_valid = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_pending) begin
          stall_from_memory = 1'b1;
          idx_d = first_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall_from_memory = 1'b1;
        dc_req_valid = 1'b1;
        if (dc_req_ready) begin
          if (!sel_we) begin
            state_d = S_WAIT;
          end else if (has_next) begin
            idx_d = next_idx;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        stall_from_memory = 1'b1;
        if (dc_resp_valid) begin
          capture = 1'b1;
          if (has_next) begin
            idx_d = next_idx;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are forced to zero whenever no request is being presented.
  always_comb begin : req_fields
    dc_req_we = 1'b0;
    dc_req_addr = '0;
    dc_req_wstrb = '0;
    dc_req_wdata = '0;
    if (state_q == S_REQ) begin
      dc_req_we = sel_we;
      dc_req_addr = {sel_addr[DATA_W-1:2], 2'b00};
      if (sel_we) begin
        case (sel_type)
          3'd0, 3'd1: begin
            dc_req_wstrb = 4'b0001 << sel_addr[1:0];
            dc_req_wdata = {4{sel_data[7:0]}};
          end
          3'd2, 3'd3: begin
            dc_req_wstrb = 4'b0011 << {sel_addr[1], 1'b0};
            dc_req_wdata = {2{sel_data[15:0]}};
          end
          default: begin
            dc_req_wstrb = 4'hF;
            dc_req_wdata = sel_data;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      for (int l = 0; l < LANES; l++) ld_buf_q[l] <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      if (capture) ld_buf_q[idx_q] <= extract(sel_type, sel_addr[1:0], dc_resp_rdata);
    end
  end

  always_comb begin : commit
    show = (state_q == S_DONE) || (state_q == S_IDLE && !any_pending);
    cmt_valid = '0;
    cmt_result = '0;
    cmt_write_reg_need = '0;
    cmt_write_reg_addr = '0;
    cmt_addr_error = '0;
    for (int l = 0; l < LANES; l++) begin
      if (show && in_valid[l]) begin
        cmt_valid[l] = 1'b1;
        cmt_result[DATA_W*l +: DATA_W] = (state_q == S_DONE && is_load[l]) ? ld_buf_q[l]
                                                                          : in_result[DATA_W*l +: DATA_W];
        cmt_write_reg_need[l] = in_write_reg_need[l] & ~mis_op[l];
        cmt_write_reg_addr[RADDR_W*l +: RADDR_W] = in_write_reg_addr[RADDR_W*l +: RADDR_W];
        cmt_addr_error[l] = mis_op[l];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_nlane.sv
// tb/tb_mem_stage_nlane.sv - scoreboard bench for mem_stage_nlane with a behavioural cache and lane model

module tb_mem_stage_nlane;

  localparam int L = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [L-1:0]  in_valid, in_read_ena, in_write_ena, in_write_reg_need;
  logic [3*L-1:0] in_mem_type;
  logic [32*L-1:0] in_addr, in_write_data, in_result;
  logic [5*L-1:0] in_write_reg_addr;
  logic          dc_req_valid, dc_req_ready, dc_req_we, dc_resp_valid;
  logic [31:0]   dc_req_addr, dc_req_wdata, dc_resp_rdata;
  logic [3:0]    dc_req_wstrb;
  logic [L-1:0]  cmt_valid, cmt_write_reg_need, cmt_addr_error;
  logic [32*L-1:0] cmt_result;
  logic [5*L-1:0] cmt_write_reg_addr;
  logic          stall_from_memory;

  always #5 clk = ~clk;

  mem_stage_nlane #(.LANES(L), .DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_read_ena(in_read_ena), .in_write_ena(in_write_ena),
    .in_mem_type(in_mem_type), .in_addr(in_addr), .in_write_data(in_write_data),
    .in_result(in_result), .in_write_reg_need(in_write_reg_need),
    .in_write_reg_addr(in_write_reg_addr),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
    .dc_req_addr(dc_req_addr), .dc_req_wstrb(dc_req_wstrb), .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .cmt_valid(cmt_valid), .cmt_result(cmt_result), .cmt_write_reg_need(cmt_write_reg_need),
    .cmt_write_reg_addr(cmt_write_reg_addr), .cmt_addr_error(cmt_addr_error),
    .stall_from_memory(stall_from_memory)
  );

  typedef struct packed {
    logic [L-1:0]    valid;
    logic [32*L-1:0] res;
    logic [L-1:0]    wrn;
    logic [5*L-1:0]  waddr;
    logic [L-1:0]    err;
  } cmt_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  cmt_t exp_cmt[$];
  req_t exp_req[$];
  logic [31:0] ref_mem [8];
  logic [31:0] cache_mem [8];
  int checks = 0;
  int errors = 0;
  int mode = 0;          // 0 random ready, 1 ready high, 2 ready low two cycles, 3 manual response
  int fixed_delay = 0;
  int acc_count = 0;
  logic man_v = 1'b0;
  logic [31:0] man_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_lanes();
    in_valid = '0; in_read_ena = '0; in_write_ena = '0; in_mem_type = '0;
    in_addr = '0; in_write_data = '0; in_result = '0;
    in_write_reg_need = '0; in_write_reg_addr = '0;
  endtask

  task automatic set_lane(input int l, input logic v, input logic rd, input logic wr,
                          input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] r, input logic need, input logic [4:0] wa);
    in_valid[l] = v; in_read_ena[l] = rd; in_write_ena[l] = wr;
    in_mem_type[3*l +: 3] = t; in_addr[32*l +: 32] = a; in_write_data[32*l +: 32] = d;
    in_result[32*l +: 32] = r; in_write_reg_need[l] = need; in_write_reg_addr[5*l +: 5] = wa;
  endtask

  // Reference: walk lanes in order against a word-array memory, then wait for the stall to drop.
  task automatic run_bundle(input int exp_stall, input string tag);
    cmt_t e;
    req_t q;
    int n;
    e.valid = in_valid; e.res = '0; e.wrn = '0; e.waddr = in_write_reg_addr; e.err = '0;
    for (int l = 0; l < L; l++) begin
      logic [2:0] t;
      logic [31:0] a, d, word, val, wd;
      logic [3:0] stb;
      int w;
      t = in_mem_type[3*l +: 3]; a = in_addr[32*l +: 32]; d = in_write_data[32*l +: 32];
      val = in_result[32*l +: 32];
      e.wrn[l] = in_write_reg_need[l];
      if (in_valid[l] && (in_read_ena[l] || in_write_ena[l])) begin
        if (((t == 2 || t == 3) && a % 2 != 0) || (t >= 4 && a % 4 != 0)) begin
          e.err[l] = 1'b1; e.wrn[l] = 1'b0;
        end else begin
          w = int'((a / 4) % 8);
          if (in_write_ena[l]) begin
            if (t <= 1) begin stb = 4'b0001 << (a % 4); wd = d[7:0] * 32'h01010101; end
            else if (t <= 3) begin stb = 4'b0011 << (a % 4); wd = d[15:0] * 32'h00010001; end
            else begin stb = 4'hF; wd = d; end
            for (int k = 0; k < 4; k++) if (stb[k]) ref_mem[w][8*k +: 8] = wd[8*k +: 8];
            q = '{1'b1, a - a % 4, stb, wd};
          end else begin
            word = ref_mem[w];
            if (t <= 1) begin
              val = (word >> (8 * (a % 4))) & 32'hFF;
              if (t == 0 && val >= 128) val = val + 32'hFFFFFF00;
            end else if (t <= 3) begin
              val = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
              if (t == 2 && val >= 32768) val = val + 32'hFFFF0000;
            end else val = word;
            q = '{1'b0, a - a % 4, 4'h0, 32'h0};
          end
          exp_req.push_back(q);
        end
      end
      e.res[32*l +: 32] = val;
    end
    exp_cmt.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall_from_memory) break;
      n++;
      if (n > 400) begin
        checks++; errors++;
        $display("FAIL %s timeout: stall high for %0d cycles, expected release", tag, n);
        break;
      end
    end
    if (exp_stall >= 0) chk({tag, " stall_cycles"}, n, exp_stall);
    @(posedge clk); #1;
  endtask

  // Commit monitor
  initial begin
    cmt_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (stall_from_memory) chk("cmt_valid_during_stall", 32'(cmt_valid), 32'h0);
        else if (cmt_valid != '0) begin
          if (exp_cmt.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_commit: got valid %b expected none", cmt_valid);
          end else begin
            e = exp_cmt.pop_front();
            chk("cmt_valid", 32'(cmt_valid), 32'(e.valid));
            for (int l = 0; l < L; l++) if (e.valid[l]) begin
              chk($sformatf("cmt_result[%0d]", l), cmt_result[32*l +: 32], e.res[32*l +: 32]);
              chk($sformatf("cmt_wrn[%0d]", l), 32'(cmt_write_reg_need[l]), 32'(e.wrn[l]));
              chk($sformatf("cmt_waddr[%0d]", l), 32'(cmt_write_reg_addr[5*l +: 5]), 32'(e.waddr[5*l +: 5]));
              chk($sformatf("cmt_err[%0d]", l), 32'(cmt_addr_error[l]), 32'(e.err[l]));
            end
          end
        end
      end
    end
  end

  // Cache model and request monitor
  initial begin
    logic pend;
    int cnt, lowcnt;
    logic [31:0] rword;
    req_t q;
    pend = 1'b0; cnt = 0; lowcnt = 0; rword = '0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) pend = 1'b0;
      else if (!dc_req_valid) begin
        chk("req_fields_idle", 32'(dc_req_we | (|dc_req_wstrb) | (|dc_req_addr) | (|dc_req_wdata)), 32'h0);
      end else if (dc_req_ready) begin
        acc_count++; lowcnt = 0;
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_request: got addr %h we %b expected none", dc_req_addr, dc_req_we);
        end else begin
          q = exp_req.pop_front();
          chk("req_we", 32'(dc_req_we), 32'(q.we));
          chk("req_addr", dc_req_addr, q.addr);
          chk("req_wstrb", 32'(dc_req_wstrb), 32'(q.wstrb));
          chk("req_wdata", dc_req_wdata, q.wdata);
        end
        if (dc_req_we) begin
          for (int k = 0; k < 4; k++)
            if (dc_req_wstrb[k]) cache_mem[(dc_req_addr / 4) % 8][8*k +: 8] = dc_req_wdata[8*k +: 8];
        end else begin
          pend = 1'b1;
          cnt = (mode == 0) ? int'($urandom_range(0, 3)) : fixed_delay;
          rword = cache_mem[(dc_req_addr / 4) % 8];
        end
      end
      @(posedge clk); #1;
      case (mode)
        0: dc_req_ready = ($urandom_range(0, 9) < 7);
        2: begin
          if (dc_req_valid) begin dc_req_ready = (lowcnt >= 2); lowcnt++; end
          else begin dc_req_ready = 1'b0; lowcnt = 0; end
        end
        default: dc_req_ready = 1'b1;
      endcase
      if (mode == 3) begin
        dc_resp_valid = man_v; dc_resp_rdata = man_d;
      end else if (pend && cnt == 0) begin
        dc_resp_valid = 1'b1; dc_resp_rdata = rword; pend = 1'b0;
      end else begin
        if (pend) cnt--;
        dc_resp_valid = (mode == 0 && !pend && $urandom_range(0, 9) == 0);
        dc_resp_rdata = $urandom;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, start;
    clear_lanes();
    for (int i = 0; i < 8; i++) begin ref_mem[i] = $urandom; cache_mem[i] = ref_mem[i]; end
    ref_mem[0] = 32'hDEADBEEF; cache_mem[0] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("reset stall", 32'(stall_from_memory), 32'h0);
    chk("reset req_valid", 32'(dc_req_valid), 32'h0);
    chk("reset cmt_valid", 32'(cmt_valid), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    mode = 1; fixed_delay = 0;
    clear_lanes();
    set_lane(0, 1, 0, 0, 3'd4, 32'h0, 32'h0, 32'h11, 1, 5'd1);
    set_lane(1, 1, 0, 0, 3'd4, 32'h0, 32'h0, 32'h22, 1, 5'd2);
    run_bundle(0, "passthru");

    fixed_delay = 2;
    clear_lanes();
    set_lane(0, 1, 1, 0, 3'd4, 32'h100, 32'h0, 32'h99, 1, 5'd3);
    run_bundle(5, "lw");

    fixed_delay = 0;
    for (int v = 0; v < 3; v++) begin
      clear_lanes();
      set_lane(0, 1, 0, 1, 3'd0, 32'h103, (v == 0) ? 32'h5A : 32'h80, 32'h77, 0, 5'd0);
      set_lane(1, 1, 1, 0, (v == 2) ? 3'd1 : 3'd0, 32'h103, 32'h0, 32'h55, 1, 5'd4);
      run_bundle(4, "sb_lb");
    end

    clear_lanes();
    set_lane(0, 1, 0, 0, 3'd4, 32'h0, 32'h0, 32'h33, 1, 5'd5);
    set_lane(1, 1, 1, 0, 3'd2, 32'h101, 32'h0, 32'h44, 1, 5'd6);
    run_bundle(0, "misaligned");

    mode = 2;
    clear_lanes();
    set_lane(0, 1, 0, 0, 3'd4, 32'h0, 32'h0, 32'hA0, 1, 5'd8);
    set_lane(1, 1, 1, 0, 3'd4, 32'h104, 32'h0, 32'hA1, 1, 5'd9);
    set_lane(2, 1, 0, 0, 3'd4, 32'h0, 32'h0, 32'hA2, 0, 5'd10);
    set_lane(3, 1, 1, 0, 3'd2, 32'h10A, 32'h0, 32'hA3, 1, 5'd11);
    run_bundle(9, "ready_low");

    // Reset while a load waits for its response, then a stale response arrives.
    mode = 3; man_v = 1'b0;
    clear_lanes();
    set_lane(0, 1, 1, 0, 3'd4, 32'h108, 32'h0, 32'hAA, 1, 5'd7);
    exp_req.push_back('{1'b0, 32'h108, 4'h0, 32'h0});
    start = acc_count; n = 0;
    while (acc_count == start && n < 50) begin @(negedge clk); n++; end
    chk("rst accepted", 32'(acc_count != start), 32'h1);
    @(posedge clk); #1;
    chk("rst wait stall", 32'(stall_from_memory), 32'h1);
    resetn = 1'b0;
    #1;
    chk("rst req_valid", 32'(dc_req_valid), 32'h0);
    chk("rst cmt_valid", 32'(cmt_valid), 32'h0);
    clear_lanes();
    man_v = 1'b1; man_d = 32'h12345678;
    @(posedge clk); #2;
    resetn = 1'b1; man_v = 1'b0;
    @(negedge clk);
    chk("late_resp stall", 32'(stall_from_memory), 32'h0);
    chk("late_resp req_valid", 32'(dc_req_valid), 32'h0);
    chk("late_resp cmt_valid", 32'(cmt_valid), 32'h0);
    @(posedge clk); #2;
    mode = 1; fixed_delay = 1;
    clear_lanes();
    set_lane(2, 1, 1, 0, 3'd4, 32'h108, 32'h0, 32'hBB, 1, 5'd12);
    run_bundle(4, "after_reset");

    mode = 0;
    for (int i = 0; i < 200; i++) begin
      clear_lanes();
      for (int l = 0; l < L; l++) begin
        int op;
        op = int'($urandom_range(0, 9));
        set_lane(l, $urandom_range(0, 3) != 0, op >= 4 && op < 7, op >= 7,
                 3'($urandom_range(0, 4)), 32'h100 + $urandom_range(0, 31), $urandom,
                 $urandom, 1'($urandom), 5'($urandom));
      end
      if (in_valid == '0) in_valid[0] = 1'b1;
      run_bundle(-1, "rand");
    end

    clear_lanes();
    repeat (5) @(negedge clk);
    chk("exp_cmt drained", exp_cmt.size(), 32'h0);
    chk("exp_req drained", exp_req.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
